// File: rtl/ei_mem_pkg.sv
// Shared register-bank definitions: bank size and burst-reader FSM states.
package ei_mem_pkg;

  localparam int unsigned EI_NUM_REGS = 43;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_RUN,
    RD_DRAIN
  } ei_rd_state_t;

endpackage

// File: rtl/ei_skid_fifo.sv
// Two-entry FIFO with occupancy output; flush empties it synchronously.
module ei_skid_fifo #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   occ_q;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop_i & (occ_q != 2'd0);
  assign push_ok = push_i & ((occ_q != 2'd2) | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

endmodule

// File: rtl/ei_reg_burst_reader.sv
// Streams a contiguous range of register-bank bytes out on a valid/ready port.
module ei_reg_burst_reader
  import ei_mem_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned NUM_REGS = EI_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  ei_rd_state_t      state_q, state_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] accepted_q, accepted_d;
  logic              inflight_q, inflight_d;
  logic              infl_last_q, infl_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              fifo_valid;
  logic [DATA_W:0]   fifo_dout;
  logic [1:0]        fifo_occ;
  logic              pop;
  logic              rd_en;
  logic              abort_run;
  logic              range_ok;
  logic [ADDR_W:0]   range_end;
  logic [2:0]        credit;
  logic              last_issue;

  assign pop        = fifo_valid & m_ready_i;
  assign abort_run  = abort_i & (state_q != RD_IDLE);
  assign range_end  = {1'b0, first_addr_i} + {1'b0, len_i};
  assign range_ok   = (len_i != '0) && (range_end <= LIMIT);
  // Buffered + in-flight bytes after this cycle's pop must leave room for one more.
  assign credit     = {1'b0, fifo_occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign last_issue = (issued_q == len_q - ADDR_W'(1));

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_en      = 1'b0;

    case (state_q)
      RD_IDLE: begin
        if (start_i) begin
          if (range_ok) begin
            state_d    = RD_RUN;
            first_d    = first_addr_i;
            len_d      = len_i;
            issued_d   = '0;
            accepted_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RD_RUN: begin
        if (!abort_i && (issued_q < len_q) && (credit < 3'd2)) begin
          rd_en    = 1'b1;
          issued_d = issued_q + ADDR_W'(1);
          if (last_issue) state_d = RD_DRAIN;
        end
      end
      default: ;
    endcase

    if (state_q != RD_IDLE && pop) begin
      accepted_d = accepted_q + ADDR_W'(1);
      if (accepted_q == len_q - ADDR_W'(1)) begin
        state_d = RD_IDLE;
        done_d  = 1'b1;
      end
    end

    inflight_d  = rd_en;
    infl_last_d = last_issue;

    if (abort_run) begin
      state_d    = RD_IDLE;
      done_d     = 1'b0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RD_IDLE;
      first_q     <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      accepted_q  <= accepted_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  ei_skid_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (abort_run),
    .push_i  (inflight_q),
    .din_i   ({infl_last_q, rd_data_i}),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .dout_o  (fifo_dout),
    .occ_o   (fifo_occ)
  );

  assign busy_o    = (state_q != RD_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rd_en_o   = rd_en;
  assign rd_addr_o = rd_en ? (first_q + issued_q) : '0;
  assign m_valid_o = fifo_valid;
  assign m_data_o  = fifo_dout[DATA_W-1:0];
  assign m_last_o  = fifo_dout[DATA_W] & fifo_valid;

endmodule
